serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits; legal range is WIDTH >= 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a_in, input, WIDTH bits: operand A, latched when start is accepted.
REQ-006 SHALL have port b_in, input, WIDTH bits: operand B, latched when start is accepted.
REQ-007 SHALL have port c_in, input, 1 bit: carry-in, latched when start is accepted.
REQ-008 SHALL have port busy, output, 1 bit: high while in ADD.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking that a new result is on sum and c_out.
REQ-010 SHALL have port sum, output, WIDTH bits: registered result of A+B+c_in, modulo 2^WIDTH.
REQ-011 SHALL have port c_out, output, 1 bit: registered carry-out of the addition.

Function
REQ-012 SHALL implement three states: IDLE, ADD and DONE.
REQ-013 SHALL accept start only in IDLE: on the accepting edge, latch a_in, b_in and c_in into internal shift and carry registers, clear the bit counter, and enter ADD.
REQ-014 SHALL, on each ADD cycle, compute one full-adder bit from the operand LSBs and the carry register (s = a^b^c, c' = ab|ac|bc), LSB first.
REQ-015 SHALL, on each ADD cycle, shift both operand registers right by one, shift s into the MSB of the internal sum register, and update the carry register.
REQ-016 SHALL spend exactly WIDTH cycles in ADD; on the edge that processes bit WIDTH-1, transfer the result to the sum and c_out outputs and enter DONE.
REQ-017 SHALL hold done high for exactly the one DONE cycle, then return to IDLE.
REQ-018 SHALL give a latency of WIDTH+1 cycles from the edge that samples start to the first cycle done is high.
REQ-019 SHALL ignore start while in ADD or DONE; no queuing, no restart.
REQ-020 SHALL keep sum and c_out stable except at the ADD-to-DONE transfer, holding the last result through IDLE.
REQ-021 SHALL treat a_in, b_in and c_in as don't-care outside the accepting edge.
REQ-022 SHALL, when start is held high continuously, begin the next operation on the first IDLE cycle after DONE, giving a throughput of one result per WIDTH+2 cycles.

Reset
REQ-023 SHALL, when rst_n is sampled low, force state IDLE and busy=0, done=0, sum=0 and c_out=0, and clear all internal registers.
REQ-024 SHALL let reset override every other input, including mid-ADD: the operation is aborted, no done pulse is produced, and the outputs are zeroed.

Configuration
REQ-025 SHALL, with macro SERIAL_ADDER_OVF_EN defined, add output port overflow (1 bit) and compute it as the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1, i.e. two's-complement overflow.
REQ-026 SHALL update overflow at the same edge as sum, hold it with sum, and reset it to 0.
REQ-027 SHALL, with SERIAL_ADDER_OVF_EN undefined, omit the overflow port and its logic entirely, with all other behaviour unchanged.

Verification
REQ-028 SHALL cover, with WIDTH=8: a_in=8'h03, b_in=8'h05, c_in=0, pulse start -> busy high for 8 cycles, done high 9 cycles after start is sampled, sum=8'h08, c_out=0.
REQ-029 SHALL cover: a_in=8'hFF, b_in=8'h01, c_in=0 -> sum=8'h00, c_out=1; then a_in=8'hFF, b_in=8'hFF, c_in=1 -> sum=8'hFF, c_out=1.
REQ-030 SHALL cover, with SERIAL_ADDER_OVF_EN defined: 8'h7F+8'h01 -> sum=8'h80, overflow=1; 8'hFF+8'h01 -> overflow=0.
REQ-031 SHALL cover: start re-pulsed with different operands during ADD and during DONE -> ignored, and the first result is unchanged.
REQ-032 SHALL cover: rst_n low for one cycle at ADD bit 4 -> next cycle busy=0, sum=0, c_out=0, and no done pulse follows.
REQ-033 SHALL cover, with WIDTH=2: all 32 combinations of a_in, b_in and c_in -> {c_out, sum} equals a_in+b_in+c_in in every case.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: latches two WIDTH-bit operands plus carry-in, adds one bit per cycle LSB first.
// Optional macro SERIAL_ADDER_OVF_EN adds a two's-complement overflow output.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] s_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s_bit;
    logic             c_next;
    logic             last_bit;
    logic [WIDTH-1:0] s_full;

    // Full-adder bit and the partial sum with the new bit shifted in at the MSB
    always_comb begin
        s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
        c_next   = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        s_full   = {s_bit, s_sh};
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    assign busy = (state == ADD);
    assign done = (state == DONE);

    // Control sequence: IDLE -> ADD for WIDTH cycles -> DONE for one cycle -> IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= ADD;
                ADD:     if (last_bit) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Operand shift registers, running carry, bit counter and result transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a_in;
                        b_sh  <= b_in;
                        carry <= c_in;
                        s_sh  <= '0;
                        cnt   <= '0;
                    end
                end
                ADD: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= c_next;
                    s_sh  <= s_full[WIDTH-1:1];
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        sum   <= s_full;
                        c_out <= c_next;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry holds the carry into the MSB on the last bit
                        overflow <= carry ^ c_next;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 instance for protocol and random
// checks, WIDTH=2 instance for exhaustive coverage.
module tb_serial_adder;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;

    logic         start2;
    logic [1:0]   a2;
    logic [1:0]   b2;
    logic         c2;
    logic         busy2;
    logic         done2;
    logic [1:0]   sum2;
    logic         cout2;

`ifdef SERIAL_ADDER_OVF_EN
    logic         overflow;
    logic         ovf2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.WIDTH(W)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .overflow (overflow)
`endif
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .a_in  (a2),
        .b_in  (b2),
        .c_in  (c2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .c_out (cout2)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .overflow (ovf2)
`endif
    );

    // Reference: plain integer addition
    function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic c);
        return {1'b0, a} + {1'b0, b} + (W+1)'(c);
    endfunction

    // Reference: signed overflow when operand signs agree and the result sign differs
    function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c);
        logic [W:0] s;
        s = model_sum(a, b, c);
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    // Pulse start with the operands, then count cycles until done (lat=0 on timeout)
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output int lat, output int bcnt, output logic [W:0] res,
                         output logic ovf);
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        c_in  = c;
        @(negedge clk);
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        c_in  = 1'($urandom);
        lat   = 0;
        bcnt  = 0;
        res   = '0;
        ovf   = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                res = {c_out, sum};
`ifdef SERIAL_ADDER_OVF_EN
                ovf = overflow;
`endif
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        a_in   = '0;
        b_in   = '0;
        c_in   = 1'b0;
        a2     = '0;
        b2     = '0;
        c2     = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, c_out, sum} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got busy=%b done=%b c_out=%b sum=%h want all 0",
                     busy, done, c_out, sum);
        end
`ifdef SERIAL_ADDER_OVF_EN
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_overflow got %b want 0", overflow);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat, bcnt;
        logic [W:0] res;
        logic ovf;
        do_op(8'h03, 8'h05, 1'b0, lat, bcnt, res, ovf);
        n_checks++;
        if (lat !== W + 1) begin
            n_fail++;
            $display("FAIL basic_latency got %0d want %0d", lat, W + 1);
        end
        n_checks++;
        if (bcnt !== W) begin
            n_fail++;
            $display("FAIL basic_busy_cycles got %0d want %0d", bcnt, W);
        end
        n_checks++;
        if (res !== 9'h008) begin
            n_fail++;
            $display("FAIL basic_result got %h want 008", res);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || sum !== 8'h08 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_after_done got done=%b busy=%b sum=%h want 0 0 08",
                     done, busy, sum);
        end
    endtask

    task automatic test_carry;
        int lat, bcnt;
        logic [W:0] res;
        logic ovf;
        do_op(8'hFF, 8'h01, 1'b0, lat, bcnt, res, ovf);
        n_checks++;
        if (res !== 9'h100) begin
            n_fail++;
            $display("FAIL carry_ff_01 got %h want 100", res);
        end
        do_op(8'hFF, 8'hFF, 1'b1, lat, bcnt, res, ovf);
        n_checks++;
        if (res !== 9'h1FF) begin
            n_fail++;
            $display("FAIL carry_ff_ff_1 got %h want 1ff", res);
        end
    endtask

    task automatic test_overflow;
`ifdef SERIAL_ADDER_OVF_EN
        int lat, bcnt;
        logic [W:0] res;
        logic ovf;
        do_op(8'h7F, 8'h01, 1'b0, lat, bcnt, res, ovf);
        n_checks++;
        if (res[W-1:0] !== 8'h80 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_7f_01 got sum=%h ovf=%b want 80 1", res[W-1:0], ovf);
        end
        do_op(8'hFF, 8'h01, 1'b0, lat, bcnt, res, ovf);
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_ff_01 got %b want 0", ovf);
        end
`endif
    endtask

    task automatic test_random;
        int lat, bcnt;
        logic [W:0] res;
        logic ovf;
        logic [W-1:0] a, b;
        logic c;
        for (int i = 0; i < 25; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            do_op(a, b, c, lat, bcnt, res, ovf);
            n_checks++;
            if (res !== model_sum(a, b, c) || lat !== W + 1) begin
                n_fail++;
                $display("FAIL random_%0d got %h lat %0d want %h lat %0d",
                         i, res, lat, model_sum(a, b, c), W + 1);
            end
`ifdef SERIAL_ADDER_OVF_EN
            n_checks++;
            if (ovf !== model_ovf(a, b, c)) begin
                n_fail++;
                $display("FAIL random_ovf_%0d got %b want %b", i, ovf, model_ovf(a, b, c));
            end
`endif
        end
    endtask

    task automatic test_ignore_start;
        int seen = 0;
        int late_busy = 0;
        @(negedge clk);
        start = 1'b1;
        a_in  = 8'h12;
        b_in  = 8'h34;
        c_in  = 1'b0;
        @(negedge clk);
        for (int n = 1; n <= W + 8; n++) begin
            if (seen != 0 && busy) late_busy++;
            if (done) begin
                seen = n;
                n_checks++;
                if ({c_out, sum} !== model_sum(8'h12, 8'h34, 1'b0)) begin
                    n_fail++;
                    $display("FAIL ignore_result got %h want %h", {c_out, sum},
                             model_sum(8'h12, 8'h34, 1'b0));
                end
            end
            start = (n == 2) || (n == 5) || done;
            a_in  = 8'hFF;
            b_in  = 8'hFF;
            c_in  = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++;
        if (seen !== W + 1 || late_busy !== 0) begin
            n_fail++;
            $display("FAIL ignore_timing got done_at=%0d late_busy=%0d want %0d 0",
                     seen, late_busy, W + 1);
        end
        n_checks++;
        if ({c_out, sum} !== 9'h046) begin
            n_fail++;
            $display("FAIL ignore_hold got %h want 046", {c_out, sum});
        end
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        @(negedge clk);
        start = 1'b1;
        a_in  = 8'h5A;
        b_in  = 8'hC3;
        c_in  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (busy !== 1'b0 || sum !== '0 || c_out !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs got busy=%b done=%b sum=%h c_out=%b want 0",
                     busy, done, sum, c_out);
        end
        for (int n = 0; n < 15; n++) begin
            if (done) dones++;
            @(negedge clk);
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL midreset_no_done got %0d pulses want 0", dones);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] qa[4];
        logic [W-1:0] qb[4];
        logic qc[4];
        int k = 0;
        int last = 0;
        for (int i = 0; i < 4; i++) begin
            qa[i] = W'($urandom);
            qb[i] = W'($urandom);
            qc[i] = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b1;
        a_in  = qa[0];
        b_in  = qb[0];
        c_in  = qc[0];
        for (int n = 1; n <= 120 && k < 4; n++) begin
            @(negedge clk);
            if (done) begin
                n_checks++;
                if ({c_out, sum} !== model_sum(qa[k], qb[k], qc[k])) begin
                    n_fail++;
                    $display("FAIL b2b_result_%0d got %h want %h", k, {c_out, sum},
                             model_sum(qa[k], qb[k], qc[k]));
                end
                n_checks++;
                if (n - last !== ((k == 0) ? W + 1 : W + 2)) begin
                    n_fail++;
                    $display("FAIL b2b_interval_%0d got %0d want %0d", k, n - last,
                             (k == 0) ? W + 1 : W + 2);
                end
                last = n;
                k++;
                if (k < 4) begin
                    a_in = qa[k];
                    b_in = qb[k];
                    c_in = qc[k];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        n_checks++;
        if (k !== 4) begin
            n_fail++;
            $display("FAIL b2b_count got %0d results want 4", k);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_width2;
        logic [2:0] got;
        logic [2:0] want;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            start2 = 1'b1;
            a2     = 2'(i >> 3);
            b2     = 2'(i >> 1);
            c2     = 1'(i);
            want   = 3'(i >> 3) + 3'((i >> 1) & 3) + 3'(i & 1);
            @(negedge clk);
            start2 = 1'b0;
            a2     = 2'($urandom);
            b2     = 2'($urandom);
            got    = 3'bxxx;
            for (int n = 1; n <= 10; n++) begin
                if (done2) begin
                    got = {cout2, sum2};
                    break;
                end
                @(negedge clk);
            end
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL w2_combo_%0d got %b want %b", i, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_overflow();
        test_ignore_start();
        test_reset_mid();
        test_random();
        test_back_to_back();
        test_width2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
